// File: rtl/game_score_ctrl.sv
// Game-progress controller: score accumulation, per-level target and countdown, win/lose decision.
// Optional build macro GAME_SCORE_TIME_BONUS_EN adds an early win with a TALLY state converting leftover seconds to points.
module game_score_ctrl #(
  parameter int BASE_TARGET    = 650,
  parameter int TARGET_STEP    = 300,
  parameter int LEVEL_SECONDS  = 60,
  parameter int FRAMES_PER_SEC = 60,
  parameter int MAX_LEVEL      = 99,
  parameter int BONUS_PER_SEC  = 10
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        start_game,
  input  logic        next_level,
  input  logic        item_collected,
  input  logic [9:0]  item_value,
  output logic [13:0] level,
  output logic [13:0] score,
  output logic [13:0] target,
  output logic [6:0]  time_left,
  output logic        playing,
  output logic        level_won,
  output logic        game_over,
  output logic        level_start
);

  localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [13:0]   SCORE_MAX  = 14'd9999;
  localparam logic [13:0]   BASE_T     = 14'((BASE_TARGET > 9999) ? 9999 : BASE_TARGET);
  localparam logic [13:0]   LEVEL_MAX  = 14'(MAX_LEVEL);
  localparam logic [6:0]    SECS       = 7'(LEVEL_SECONDS);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);

  typedef enum logic [2:0] {
    IDLE,
    PLAYING,
    LEVEL_WON,
    GAME_OVER
`ifdef GAME_SCORE_TIME_BONUS_EN
    , TALLY
`endif
  } state_t;

  state_t        state_reg, state_next;
  logic [13:0]   level_reg, level_next;
  logic [13:0]   score_reg, score_next;
  logic [13:0]   target_reg, target_next;
  logic [6:0]    time_left_reg, time_left_next;
  logic [FW-1:0] frame_cnt_reg, frame_cnt_next;
  logic          level_start_reg, level_start_next;
  logic          playing_reg, playing_next;
  logic          level_won_reg, game_over_reg;

  logic [14:0]   item_sum, step_sum;
  logic [13:0]   score_post;
  logic          tick, timeout;
`ifdef GAME_SCORE_TIME_BONUS_EN
  logic [14:0]   bonus_sum;
`endif

  function automatic logic [13:0] sat14(input logic [14:0] v);
    return (v > {1'b0, SCORE_MAX}) ? SCORE_MAX : v[13:0];
  endfunction

  always_comb begin
    state_next       = state_reg;
    level_next       = level_reg;
    score_next       = score_reg;
    target_next      = target_reg;
    time_left_next   = time_left_reg;
    frame_cnt_next   = frame_cnt_reg;
    level_start_next = 1'b0;

    item_sum   = {1'b0, score_reg} + {5'd0, item_value};
    // Target grows by one step per level; saturation makes the running sum equal the closed form.
    step_sum   = {1'b0, target_reg} + 15'(TARGET_STEP);
    score_post = item_collected ? sat14(item_sum) : score_reg;
    tick       = startOfFrame && (frame_cnt_reg == FRAME_LAST);
    timeout    = tick && (time_left_reg == 7'd1);
`ifdef GAME_SCORE_TIME_BONUS_EN
    bonus_sum  = {1'b0, score_reg} + 15'(BONUS_PER_SEC);
`endif

    case (state_reg)
      IDLE: begin
        if (start_game) begin
          state_next       = PLAYING;
          level_start_next = 1'b1;
        end
      end
      PLAYING: begin
        score_next = score_post;
        if (startOfFrame)
          frame_cnt_next = tick ? '0 : frame_cnt_reg + 1'b1;
        if (tick && time_left_reg != 7'd0)
          time_left_next = time_left_reg - 7'd1;
`ifdef GAME_SCORE_TIME_BONUS_EN
        if (item_collected && score_post >= target_reg)
          state_next = TALLY;
        else
`endif
        if (timeout)
          state_next = (score_post >= target_reg) ? LEVEL_WON : GAME_OVER;
      end
      LEVEL_WON: begin
        if (next_level) begin
          if (level_reg < LEVEL_MAX) begin
            level_next  = level_reg + 14'd1;
            target_next = sat14(step_sum);
          end
          time_left_next   = SECS;
          frame_cnt_next   = '0;
          state_next       = PLAYING;
          level_start_next = 1'b1;
        end
      end
      GAME_OVER: begin
        if (start_game) begin
          level_next       = 14'd1;
          score_next       = '0;
          target_next      = BASE_T;
          time_left_next   = SECS;
          frame_cnt_next   = '0;
          state_next       = PLAYING;
          level_start_next = 1'b1;
        end
      end
`ifdef GAME_SCORE_TIME_BONUS_EN
      TALLY: begin
        if (time_left_reg != 7'd0) begin
          time_left_next = time_left_reg - 7'd1;
          score_next     = sat14(bonus_sum);
        end
        if (time_left_reg <= 7'd1)
          state_next = LEVEL_WON;
      end
`endif
      default: state_next = IDLE;
    endcase

    playing_next = (state_next == PLAYING);
`ifdef GAME_SCORE_TIME_BONUS_EN
    if (state_next == TALLY)
      playing_next = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_reg       <= IDLE;
      level_reg       <= 14'd1;
      score_reg       <= '0;
      target_reg      <= BASE_T;
      time_left_reg   <= SECS;
      frame_cnt_reg   <= '0;
      level_start_reg <= 1'b0;
      playing_reg     <= 1'b0;
      level_won_reg   <= 1'b0;
      game_over_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      level_reg       <= level_next;
      score_reg       <= score_next;
      target_reg      <= target_next;
      time_left_reg   <= time_left_next;
      frame_cnt_reg   <= frame_cnt_next;
      level_start_reg <= level_start_next;
      playing_reg     <= playing_next;
      level_won_reg   <= (state_next == LEVEL_WON);
      game_over_reg   <= (state_next == GAME_OVER);
    end
  end

  assign level       = level_reg;
  assign score       = score_reg;
  assign target      = target_reg;
  assign time_left   = time_left_reg;
  assign playing     = playing_reg;
  assign level_won   = level_won_reg;
  assign game_over   = game_over_reg;
  assign level_start = level_start_reg;

endmodule

// File: tb/tb_game_score_ctrl.sv
// Testbench for game_score_ctrl: directed scenarios plus random traffic against a rule-level reference model.
module tb_game_score_ctrl;

  localparam int FPS   = 4;   // short seconds keep the march to the level cap affordable
  localparam int SECS  = 60;
  localparam int BASE  = 650;
  localparam int STEP  = 300;
  localparam int MAXL  = 99;
  localparam int S_IDLE = 0, S_PLAY = 1, S_WON = 2, S_OVER = 3;

  logic        clk = 1'b0;
  logic        resetN = 1'b0, startOfFrame = 1'b0, start_game = 1'b0;
  logic        next_level = 1'b0, item_collected = 1'b0;
  logic [9:0]  item_value = '0;
  logic [13:0] level, score, target;
  logic [6:0]  time_left;
  logic        playing, level_won, game_over, level_start;

  int n_checks = 0;
  int n_errors = 0;

  int m_state, m_level, m_score, m_target, m_time, m_frames;
  bit m_ls;

  game_score_ctrl #(
    .BASE_TARGET(BASE), .TARGET_STEP(STEP), .LEVEL_SECONDS(SECS),
    .FRAMES_PER_SEC(FPS), .MAX_LEVEL(MAXL), .BONUS_PER_SEC(10)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .start_game(start_game), .next_level(next_level),
    .item_collected(item_collected), .item_value(item_value),
    .level(level), .score(score), .target(target), .time_left(time_left),
    .playing(playing), .level_won(level_won), .game_over(game_over),
    .level_start(level_start)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int tgt_for(input int lv);
    int t;
    t = BASE + (lv - 1) * STEP;
    return (t > 9999) ? 9999 : t;
  endfunction

  function automatic void model_reset();
    m_state = S_IDLE; m_level = 1; m_score = 0; m_target = BASE;
    m_time = SECS; m_frames = 0; m_ls = 0;
  endfunction

  function automatic void model_step(input bit rn, sof, sg, nl, ic, input int iv);
    m_ls = 0;
    if (!rn) begin
      model_reset();
      return;
    end
    case (m_state)
      S_IDLE: if (sg) begin m_state = S_PLAY; m_ls = 1; end
      S_PLAY: begin
        if (ic) m_score = (m_score + iv > 9999) ? 9999 : m_score + iv;
        if (sof) begin
          m_frames++;
          if (m_frames == FPS) begin
            m_frames = 0;
            if (m_time > 0) begin
              m_time--;
              if (m_time == 0) m_state = (m_score >= m_target) ? S_WON : S_OVER;
            end
          end
        end
      end
      S_WON: if (nl) begin
        m_level = (m_level < MAXL) ? m_level + 1 : MAXL;
        m_target = tgt_for(m_level);
        m_time = SECS; m_frames = 0; m_state = S_PLAY; m_ls = 1;
      end
      S_OVER: if (sg) begin
        m_level = 1; m_score = 0; m_target = BASE; m_time = SECS;
        m_frames = 0; m_state = S_PLAY; m_ls = 1;
      end
      default: model_reset();
    endcase
  endfunction

  task automatic compare_all();
    check_eq("level", int'(level), m_level);
    check_eq("score", int'(score), m_score);
    check_eq("target", int'(target), m_target);
    check_eq("time_left", int'(time_left), m_time);
    check_eq("playing", int'(playing), int'(m_state == S_PLAY));
    check_eq("level_won", int'(level_won), int'(m_state == S_WON));
    check_eq("game_over", int'(game_over), int'(m_state == S_OVER));
    check_eq("level_start", int'(level_start), int'(m_ls));
  endtask

  task automatic cycle(input bit rn, sof, sg, nl, ic, input int iv);
    resetN = rn; startOfFrame = sof; start_game = sg; next_level = nl;
    item_collected = ic; item_value = 10'(iv);
    @(posedge clk);
    model_step(rn, sof, sg, nl, ic, iv);
    #1;
    compare_all();
    resetN = 1'b1; startOfFrame = 1'b0; start_game = 1'b0;
    next_level = 1'b0; item_collected = 1'b0; item_value = '0;
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) cycle(1, 1, 0, 0, 0, 0);
  endtask

  task automatic item(input int v);
    cycle(1, 0, 0, 0, 1, v);
  endtask

  task automatic restart();
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
  endtask

  initial begin
    // Reset and first start
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check_eq("rst_level", int'(level), 1);
    check_eq("rst_target", int'(target), 650);
    check_eq("rst_time", int'(time_left), 60);
    cycle(1, 0, 1, 0, 0, 0);
    check_eq("start_pulse", int'(level_start), 1);
    check_eq("start_playing", int'(playing), 1);
    cycle(1, 0, 0, 0, 0, 0);
    check_eq("pulse_once", int'(level_start), 0);

    // Win level 1, advance to level 2
    item(400);
    check_eq("score_400", int'(score), 400);
    item(300);
    check_eq("score_700", int'(score), 700);
    run_frames(SECS * FPS);
    check_eq("won_flag", int'(level_won), 1);
    check_eq("won_time", int'(time_left), 0);
    cycle(1, 0, 0, 1, 0, 0);
    check_eq("l2_level", int'(level), 2);
    check_eq("l2_target", int'(target), 950);
    check_eq("l2_score", int'(score), 700);
    check_eq("l2_time", int'(time_left), 60);

    // Item on the final tick counts toward the win
    restart();
    item(640);
    run_frames(SECS * FPS - 1);
    cycle(1, 1, 0, 0, 1, 10);
    check_eq("edge_score", int'(score), 650);
    check_eq("edge_won", int'(level_won), 1);
    check_eq("edge_over", int'(game_over), 0);

    // Lose, items ignored, restart from GAME_OVER
    restart();
    item(100);
    run_frames(SECS * FPS);
    check_eq("lose_over", int'(game_over), 1);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 1, 500);
    check_eq("over_hold", int'(score), 100);
    cycle(1, 0, 1, 1, 0, 0);
    check_eq("re_level", int'(level), 1);
    check_eq("re_score", int'(score), 0);
    check_eq("re_playing", int'(playing), 1);

    // Score saturation, then march to the level cap
    for (int i = 0; i < 9; i++) item(1023);
    item(783);
    check_eq("score_9990", int'(score), 9990);
    item(1023);
    check_eq("score_sat", int'(score), 9999);
    for (int lv = 1; lv <= MAXL; lv++) begin
      run_frames(SECS * FPS);
      cycle(1, 0, 1, 1, 0, 0);
    end
    check_eq("level_cap", int'(level), 99);
    check_eq("target_sat", int'(target), 9999);

    // Mid-level reset
    restart();
    item(500);
    run_frames(30 * FPS + 1);
    check_eq("mid_time", int'(time_left), 30);
    cycle(0, 1, 0, 0, 1, 5);
    check_eq("mid_rst_score", int'(score), 0);
    check_eq("mid_rst_playing", int'(playing), 0);
    cycle(1, 0, 1, 0, 0, 0);
    run_frames(FPS - 1);
    check_eq("frame_rst_a", int'(time_left), 60);
    run_frames(1);
    check_eq("frame_rst_b", int'(time_left), 59);

    // Random traffic
    for (int i = 0; i < 15000; i++) begin
      cycle(($urandom_range(0, 2999) != 0), ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 7) == 0), int'($urandom_range(0, 1023)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
